latch_bank: RTL

Parametrised multi-channel load register: the edge-triggered, multi-channel successor to the single-bit load latch. Each of CHANNELS lanes holds a WIDTH-bit value captured on its own load strobe, reports a sticky "changed" flag until acknowledged, and keeps a saturating load counter. It sits between control/status sources and downstream logic that needs stable, individually updated values with change notification.

---
 rtl/latch_bank_pkg.sv | 18 +
 rtl/latch_bank_chan.sv | 117 +++++++++++
 rtl/latch_bank.sv | 54 +++++
 3 files changed

// File: rtl/latch_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : latch_bank_pkg                                                  |
// | Purpose  : Shared defaults for the latch_bank channel bank: data width,    |
// |            channel count, counter width and the saturated counter value.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package latch_bank_pkg;

  localparam int C_DEF_WIDTH    = 8;
  localparam int C_DEF_CHANNELS = 4;
  localparam int C_DEF_CNT_W    = 8;

  // All-ones value a default-width load counter stops at.
  localparam logic [C_DEF_CNT_W-1:0] C_CNT_SAT = '1;

endpackage : latch_bank_pkg
`default_nettype wire

// File: rtl/latch_bank_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : latch_bank_chan                                                 |
// | Purpose  : One channel of latch_bank: held value, optional shadow value,   |
// |            sticky changed flag and saturating load counter.               |
// | Ports    : clk, rst (async, active-high)                                   |
// |            data[WIDTH]   value to capture      load   capture strobe       |
// |            clear         zero all channel state ack    clear changed flag  |
// |            commit        shadow -> dout (shadow build only)                |
// |            dout[WIDTH]   held value            changed sticky change flag  |
// |            load_cnt[CNT_W] saturating count of accepted loads            |
// | Config   : LATCH_BANK_SHADOW_EN adds the shadow register and commit path.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module latch_bank_chan
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int CNT_W = C_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             clear,
  input  logic             ack,
  input  logic             commit,
  output logic [WIDTH-1:0] dout,
  output logic             changed,
  output logic [CNT_W-1:0] load_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [WIDTH-1:0] value_d, value_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             changed_d, changed_q;
  logic             w_set_chg;

`ifdef LATCH_BANK_SHADOW_EN
  logic [WIDTH-1:0] shadow_d, shadow_q;
`else
  logic             unused_commit;
  assign unused_commit = commit;
`endif

  always_comb begin
    value_d   = value_q;
    cnt_d     = cnt_q;
    w_set_chg = 1'b0;
`ifdef LATCH_BANK_SHADOW_EN
    shadow_d  = shadow_q;
`endif
    if (clear) begin
      value_d = '0;
      cnt_d   = '0;
`ifdef LATCH_BANK_SHADOW_EN
      shadow_d = '0;
`endif
    end else begin
      if (load) begin
        cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
`ifdef LATCH_BANK_SHADOW_EN
      if (load) begin
        shadow_d = data;
      end
      // Commit moves the pre-edge shadow, so a same-cycle load waits for
      // the next commit.
      if (commit) begin
        value_d   = shadow_q;
        w_set_chg = (shadow_q != value_q);
      end
`else
      if (load) begin
        value_d   = data;
        w_set_chg = (data != value_q);
      end
`endif
    end

    // A set event beats a same-cycle acknowledge; clear beats both.
    if (clear) begin
      changed_d = 1'b0;
    end else if (w_set_chg) begin
      changed_d = 1'b1;
    end else if (ack) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q   <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
`ifdef LATCH_BANK_SHADOW_EN
      shadow_q  <= '0;
`endif
    end else begin
      value_q   <= value_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
`ifdef LATCH_BANK_SHADOW_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  assign dout     = value_q;
  assign changed  = changed_q;
  assign load_cnt = cnt_q;

endmodule : latch_bank_chan
`default_nettype wire

// File: rtl/latch_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : latch_bank                                                      |
// | Purpose  : CHANNELS independent load registers with sticky change flags    |
// |            and saturating load counters.                                  |
// | Ports    : clk, rst (async, active-high)                                   |
// |            data[CHANNELS*WIDTH]  packed inputs, channel i at i*WIDTH       |
// |            load/clear/ack[CHANNELS] per-channel strobes                    |
// |            commit                shadow -> dout (shadow build only)        |
// |            dout[CHANNELS*WIDTH]  held values, same packing as data         |
// |            changed[CHANNELS]     sticky change flags                       |
// |            load_cnt[CHANNELS*CNT_W] counters, channel i at i*CNT_W         |
// | Config   : LATCH_BANK_SHADOW_EN enables per-channel shadow + commit.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int WIDTH    = C_DEF_WIDTH,
  parameter int CHANNELS = C_DEF_CHANNELS,
  parameter int CNT_W    = C_DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       ack,
  input  logic                      commit,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS*CNT_W-1:0] load_cnt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    latch_bank_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .data     (data[i*WIDTH +: WIDTH]),
      .load     (load[i]),
      .clear    (clear[i]),
      .ack      (ack[i]),
      .commit   (commit),
      .dout     (dout[i*WIDTH +: WIDTH]),
      .changed  (changed[i]),
      .load_cnt (load_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule : latch_bank
`default_nettype wire
